// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: signal bundle between the control sequencer (master) and the
// datapath / memory side (slave). The optional step input appears only when
// CTRL_SINGLE_STEP_EN is defined.
//
// Memory handshake: mem_req is raised by the sequencer and held steady
// until a cycle in which mem_ack is high; that cycle completes the transfer,
// and mem_ack in any cycle without mem_req is ignored.
interface cpu_ctrl_if;
  logic       start;
  logic [4:0] op;
  logic       zf;
  logic       cf;
  logic       nf;
  logic       mem_ack;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
`endif
  logic       mem_req;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       alusrc;
  logic [1:0] aluop;
  logic       flag_we;
  logic       reg_we;
  logic       mem_to_reg;
  logic       retire;
  logic       halted;
  logic       illegal;
  logic       bus_err;

  modport master (
`ifdef CTRL_SINGLE_STEP_EN
    input  step,
`endif
    input  start, op, zf, cf, nf, mem_ack,
    output mem_req, mem_we, ir_we, pc_we, pc_src, alusrc, aluop,
    output flag_we, reg_we, mem_to_reg, retire, halted, illegal, bus_err
  );

  modport slave (
`ifdef CTRL_SINGLE_STEP_EN
    output step,
`endif
    output start, op, zf, cf, nf, mem_ack,
    input  mem_req, mem_we, ir_we, pc_we, pc_src, alusrc, aluop,
    input  flag_we, reg_we, mem_to_reg, retire, halted, illegal, bus_err
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer (fetch, decode, execute,
// memory, writeback) for the 5-bit opcode set.
// Optional macro CTRL_SINGLE_STEP_EN adds a PAUSE state entered after every
// retiring instruction and left on a step pulse.
// MEM_TIMEOUT = 0 waits forever for mem_ack; N > 0 flags bus_err and halts
// after N consecutive unacknowledged FETCH or MEM cycles.
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_ctrl_if.master        bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
`ifdef CTRL_SINGLE_STEP_EN
    , S_PAUSE = 3'd7
`endif
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_IMM, C_MEM, C_BR, C_JMP, C_NOP, C_HLT, C_ILL
  } op_class_e;

  localparam logic [4:0] OP_ADD   = 5'b10000;
  localparam logic [4:0] OP_SUB   = 5'b00011;
  localparam logic [4:0] OP_CMP   = 5'b01001;
  localparam logic [4:0] OP_ADDI  = 5'b10011;
  localparam logic [4:0] OP_SUBI  = 5'b01110;
  localparam logic [4:0] OP_LDIH  = 5'b01111;
  localparam logic [4:0] OP_LOAD  = 5'b10001;
  localparam logic [4:0] OP_STORE = 5'b10010;
  localparam logic [4:0] OP_BZ    = 5'b10100;
  localparam logic [4:0] OP_BNZ   = 5'b10101;
  localparam logic [4:0] OP_BC    = 5'b10110;
  localparam logic [4:0] OP_BNC   = 5'b10111;
  localparam logic [4:0] OP_BN    = 5'b11000;
  localparam logic [4:0] OP_BNN   = 5'b11001;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e     state;
  state_e     state_next;
  state_e     retire_next;
  op_class_e  op_class;
  logic       taken;
  logic [1:0] aluop_sel;
  logic [CW-1:0] wait_cnt;
  logic       timeout;
  logic       set_illegal;
  logic       set_bus_err;
  logic       illegal_q;
  logic       bus_err_q;

  logic       mem_req, mem_we, ir_we, pc_we, alusrc;
  logic       flag_we, reg_we, mem_to_reg, retire, halted;
  logic [1:0] pc_src, aluop;

`ifdef CTRL_SINGLE_STEP_EN
  assign retire_next = S_PAUSE;
`else
  assign retire_next = S_FETCH;
`endif

  // Current wait cycle is the last allowed one without an acknowledge.
  assign timeout = (MEM_TIMEOUT > 0) && (wait_cnt == LIMIT);

  // Sort the opcode into the class that steers DECODE and EXEC.
  always_comb begin
    op_class = C_ILL;
    case (bus.op)
      5'b00000, 5'b00001: op_class = C_NOP;
      5'b00010, 5'b11010: op_class = C_JMP;
      5'b10000, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101:
        op_class = C_ALU;
      5'b10011, 5'b01110, 5'b01111: op_class = C_IMM;
      5'b10001, 5'b10010: op_class = C_MEM;
      5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11000, 5'b11001:
        op_class = C_BR;
      5'b11011: op_class = C_HLT;
      default: op_class = C_ILL;
    endcase
  end

  // Branch condition from the flags as they stand during EXEC.
  always_comb begin
    taken = 1'b0;
    case (bus.op)
      OP_BZ:   taken = bus.zf;
      OP_BNZ:  taken = !bus.zf;
      OP_BC:   taken = bus.cf;
      OP_BNC:  taken = !bus.cf;
      OP_BN:   taken = bus.nf;
      OP_BNN:  taken = !bus.nf;
      default: taken = 1'b0;
    endcase
  end

  // ALU operation class handed to the ALU decoder.
  always_comb begin
    aluop_sel = 2'b10;
    case (bus.op)
      OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: aluop_sel = 2'b00;
      OP_SUB, OP_SUBI:                    aluop_sel = 2'b01;
      default: aluop_sel = ((op_class == C_BR) || (op_class == C_JMP)) ? 2'b11 : 2'b10;
    endcase
  end

  // Next-state and strobe decode; every output defaults low.
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'b00;
    alusrc      = 1'b0;
    aluop       = 2'b00;
    flag_we     = 1'b0;
    reg_we      = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_DECODE: begin
        case (op_class)
          C_NOP: begin
            retire     = 1'b1;
            state_next = retire_next;
          end
          C_HLT: begin
            retire     = 1'b1;
            state_next = S_HALT;
          end
          C_ILL: begin
            set_illegal = 1'b1;
            state_next  = S_HALT;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        aluop  = aluop_sel;
        alusrc = (op_class == C_IMM) || (op_class == C_MEM);
        case (op_class)
          C_ALU: begin
            flag_we = 1'b1;
            if (bus.op == OP_CMP) begin
              retire     = 1'b1;
              state_next = retire_next;
            end else begin
              state_next = S_WB;
            end
          end
          C_IMM: begin
            flag_we    = (bus.op != OP_LDIH);
            state_next = S_WB;
          end
          C_BR: begin
            if (taken) begin
              pc_we  = 1'b1;
              pc_src = 2'b01;
            end
            retire     = 1'b1;
            state_next = retire_next;
          end
          C_JMP: begin
            pc_we      = 1'b1;
            pc_src     = 2'b10;
            retire     = 1'b1;
            state_next = retire_next;
          end
          C_MEM:   state_next = S_MEM;
          default: state_next = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (bus.op == OP_STORE);
        if (bus.mem_ack) begin
          if (bus.op == OP_STORE) begin
            retire     = 1'b1;
            state_next = retire_next;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (bus.op == OP_LOAD);
        retire     = 1'b1;
        state_next = retire_next;
      end
      S_HALT: begin
        halted = 1'b1;
      end
`ifdef CTRL_SINGLE_STEP_EN
      S_PAUSE: begin
        if (bus.step) state_next = S_FETCH;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any instruction or memory request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Wait counter: counts consecutive unacknowledged FETCH/MEM cycles and
  // restarts from zero on every entry into either state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (((state == S_FETCH) || (state == S_MEM)) && (state_next == state)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      illegal_q <= illegal_q | set_illegal;
      bus_err_q <= bus_err_q | set_bus_err;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_src     = pc_src;
  assign bus.alusrc     = alusrc;
  assign bus.aluop      = aluop;
  assign bus.flag_we    = flag_we;
  assign bus.reg_we     = reg_we;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.retire     = retire;
  assign bus.halted     = halted;
  assign bus.illegal    = illegal_q;
  assign bus.bus_err    = bus_err_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed bench for cpu_ctrl_fsm. DUT a uses the default
// MEM_TIMEOUT (wait forever), DUT b uses MEM_TIMEOUT = 4.
// Output word layout used for expected values (16 bits):
//   {mem_req, mem_we, ir_we, pc_we}_{pc_src}_{alusrc}_{aluop}_
//   {flag_we, reg_we, mem_to_reg, retire}_{halted, illegal, bus_err}
// State debug encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5,
// HALT 6, PAUSE 7.
module tb_cpu_ctrl_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic [4:0] op;
  logic       zf, cf, nf, mem_ack;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
`endif
  logic [2:0] st_a, st_b;

  cpu_ctrl_if ifa ();
  cpu_ctrl_if ifb ();

  assign ifa.start   = start_a;
  assign ifa.op      = op;
  assign ifa.zf      = zf;
  assign ifa.cf      = cf;
  assign ifa.nf      = nf;
  assign ifa.mem_ack = mem_ack;
  assign ifb.start   = start_b;
  assign ifb.op      = op;
  assign ifb.zf      = zf;
  assign ifb.cf      = cf;
  assign ifb.nf      = nf;
  assign ifb.mem_ack = mem_ack;
`ifdef CTRL_SINGLE_STEP_EN
  assign ifa.step    = step;
  assign ifb.step    = step;
`endif

  cpu_ctrl_fsm u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifa),
    .state_dbg (st_a)
  );

  cpu_ctrl_fsm #(.MEM_TIMEOUT(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifb),
    .state_dbg (st_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic        ack_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] outs(input bit b);
    if (b)
      return {ifb.mem_req, ifb.mem_we, ifb.ir_we, ifb.pc_we, ifb.pc_src, ifb.alusrc,
              ifb.aluop, ifb.flag_we, ifb.reg_we, ifb.mem_to_reg, ifb.retire,
              ifb.halted, ifb.illegal, ifb.bus_err};
    return {ifa.mem_req, ifa.mem_we, ifa.ir_we, ifa.pc_we, ifa.pc_src, ifa.alusrc,
            ifa.aluop, ifa.flag_we, ifa.reg_we, ifa.mem_to_reg, ifa.retire,
            ifa.halted, ifa.illegal, ifa.bus_err};
  endfunction

  function automatic logic [2:0] st(input bit b);
    return b ? st_b : st_a;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ack, input logic [15:0] e);
    ack_q.push_back(ack);
    exp_q.push_back(e);
  endtask

  task automatic kick(input bit b);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    check("start_to_fetch", 32'(st(b)), 32'd1);
  endtask

  // Replays the queued cycles: one mem_ack value and one expected word each.
  task automatic run_q(input string tag, input bit b, input bit retiring);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      mem_ack = ack_q.pop_front();
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i), 32'(outs(b)), 32'(exp_q.pop_front()));
      tick();
      i++;
    end
    mem_ack = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    if (retiring) begin
      check({tag, "_pause"}, 32'(st(b)), 32'd7);
      step = 1'b1;
      tick();
      step = 1'b0;
      check({tag, "_step_fetch"}, 32'(st(b)), 32'd1);
    end
`else
    if (retiring) check({tag, "_next_fetch"}, 32'(st(b)), 32'd1);
`endif
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_outs_a", 32'(outs(1'b0)), 32'd0);
    check("rst_state_a", 32'(st_a), 32'd0);
    check("rst_outs_b", 32'(outs(1'b1)), 32'd0);
    check("rst_state_b", 32'(st_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    op      = 5'b00000;
    zf      = 1'b0;
    cf      = 1'b0;
    nf      = 1'b0;
    mem_ack = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    step    = 1'b0;
`endif
    #12;
    check("por_outs_a", 32'(outs(1'b0)), 32'd0);
    check("por_state_a", 32'(st_a), 32'd0);
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_holds", 32'(st_a), 32'd0);

    kick(1'b0);

    // ADD: F, D, E, W with mem_ack held high (ignored outside FETCH/MEM).
    op = 5'b10000;
    push(1, 16'b1011_00_0_00_0000_000);
    push(1, 16'b0000_00_0_00_0000_000);
    push(1, 16'b0000_00_0_00_1000_000);
    push(1, 16'b0000_00_0_00_0101_000);
    run_q("add", 1'b0, 1'b1);

    // CMP: flags written, retires from EXEC.
    op = 5'b01001;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0000_00_0_10_1001_000);
    run_q("cmp", 1'b0, 1'b1);

    // BZ taken.
    op = 5'b10100; zf = 1'b1;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0001_01_0_11_0001_000);
    run_q("bz_taken", 1'b0, 1'b1);

    // BZ not taken.
    zf = 1'b0;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0000_00_0_11_0001_000);
    run_q("bz_not", 1'b0, 1'b1);

    // JMPR: jump target.
    op = 5'b11010;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0001_10_0_11_0001_000);
    run_q("jmpr", 1'b0, 1'b1);

    // LDIH: immediate, no flag write.
    op = 5'b01111;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0000_00_1_10_0000_000);
    push(0, 16'b0000_00_0_00_0101_000);
    run_q("ldih", 1'b0, 1'b1);

    // SUBI: immediate subtract with flag write.
    op = 5'b01110;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0000_00_1_01_1000_000);
    push(0, 16'b0000_00_0_00_0101_000);
    run_q("subi", 1'b0, 1'b1);

    // NOP after a 6-cycle fetch stall (no timeout on DUT a).
    op = 5'b00001;
    for (int k = 0; k < 6; k++) push(0, 16'b1000_00_0_00_0000_000);
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0001_000);
    run_q("nop_stall", 1'b0, 1'b1);

    // LOAD, ack on the 4th MEM cycle: retire on cycle 8.
    op = 5'b10001;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0000_00_1_00_0000_000);
    push(0, 16'b1000_00_0_00_0000_000);
    push(0, 16'b1000_00_0_00_0000_000);
    push(0, 16'b1000_00_0_00_0000_000);
    push(1, 16'b1000_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0111_000);
    run_q("load", 1'b0, 1'b1);

    // STORE with immediate ack: retires from MEM.
    op = 5'b10010;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0000_00_1_00_0000_000);
    push(1, 16'b1100_00_0_00_0001_000);
    run_q("store", 1'b0, 1'b1);

`ifdef CTRL_SINGLE_STEP_EN
    // Two NOPs: PAUSE holds without step, FETCH only after a step pulse.
    op = 5'b00001;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0001_000);
    run_q("ss_nop1", 1'b0, 1'b0);
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("ss_hold_st%0d", k), 32'(st_a), 32'd7);
      check($sformatf("ss_hold_out%0d", k), 32'(outs(1'b0)), 32'd0);
      tick();
    end
    mem_ack = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("ss_step_fetch", 32'(st_a), 32'd1);
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0001_000);
    run_q("ss_nop2", 1'b0, 1'b1);
`endif

    // Illegal opcode 11101: halt with illegal set; start and ack ignored.
    op = 5'b11101;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    run_q("ill_fd", 1'b0, 1'b0);
    start_a = 1'b1;
    push(1, 16'b0000_00_0_00_0000_110);
    push(1, 16'b0000_00_0_00_0000_110);
    push(0, 16'b0000_00_0_00_0000_110);
    run_q("ill_halt", 1'b0, 1'b0);
    start_a = 1'b0;
    check("ill_state", 32'(st_a), 32'd6);
    apply_reset();

    // DUT b: STORE never acknowledged -> bus_err and HALT after 4 MEM cycles.
    kick(1'b1);
    op = 5'b10010;
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0000_00_1_00_0000_000);
    for (int k = 0; k < 4; k++) push(0, 16'b1100_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_101);
    run_q("timeout", 1'b1, 1'b0);
    check("timeout_state", 32'(st_b), 32'd6);
    apply_reset();

    // DUT b: reset asserted mid-MEM drops mem_req without a clock edge.
    kick(1'b1);
    push(1, 16'b1011_00_0_00_0000_000);
    push(0, 16'b0000_00_0_00_0000_000);
    push(0, 16'b0000_00_1_00_0000_000);
    push(0, 16'b1100_00_0_00_0000_000);
    run_q("midmem", 1'b1, 1'b0);
    check("midmem_req", 32'(ifb.mem_req), 32'd1);
    apply_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
